// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state codes, memory op length codes, memory type codes.
// Latency: none (definitions only).
// Backpressure: n/a.
package data_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

    // mem_op_length codes, shared with the instruction decoder
    localparam logic [2:0] MEM_OP_BYTE = 3'd0;
    localparam logic [2:0] MEM_OP_HALF = 3'd1;
    localparam logic [2:0] MEM_OP_WORD = 3'd2;

    // memory type codes
    localparam logic MEM_RAM = 1'b0;
    localparam logic MEM_ROM = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter_2.sv
// Combinational 2-way grant: round-robin on ties, or port 0 always on ties when fixed_prio is set.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the grant is consumed.
module rr_arbiter_2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    input  logic fixed_prio,
    output logic gnt_vld,
    output logic gnt_idx
);

    // A lone requester always wins; on a tie the port not granted last time wins
    always_comb begin
        gnt_vld = req0 | req1;
        gnt_idx = 1'b0;
        if (req0 && req1) begin
            gnt_idx = fixed_prio ? 1'b0 : ~last_grant;
        end else if (req1) begin
            gnt_idx = 1'b1;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one data RAM between the CPU MEM stage (port 0) and the loader/debug port (port 1); define DATA_MEM_ARB_FIXED_PRIO_EN for fixed port-0 priority.
// Latency: req seen in IDLE at cycle N -> write ack at N+2, read ack at N+2+RAM_LATENCY.
// Backpressure: requests are sampled only in IDLE; a requester holds req until its one-cycle ack.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int RAM_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_write,
    input  logic [2:0]        p0_len,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_write,
    input  logic [2:0]        p1_len,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              ram_read,
    output logic              ram_write,
    output logic [2:0]        ram_len,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              owner
);

`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
    localparam logic FIXED_PRIO = 1'b1;
`else
    localparam logic FIXED_PRIO = 1'b0;
`endif

    // last WAIT count value; the capture happens RAM_LATENCY cycles after ISSUE
    localparam logic [2:0] LAT_LAST = 3'(RAM_LATENCY - 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [2:0]        cnt;
    logic              last_grant;
    logic              lat_write;
    logic [2:0]        lat_len;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic              gnt_vld;
    logic              gnt_idx;

    rr_arbiter_2 u_rr (
        .req0       (p0_req),
        .req1       (p1_req),
        .last_grant (last_grant),
        .fixed_prio (FIXED_PRIO),
        .gnt_vld    (gnt_vld),
        .gnt_idx    (gnt_idx)
    );

    // Next-state: IDLE -> ISSUE -> (WAIT for reads) -> RESP -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:  if (gnt_vld) state_nxt = ARB_ISSUE;
            ARB_ISSUE: state_nxt = lat_write ? ARB_RESP : ARB_WAIT;
            ARB_WAIT:  if (cnt == LAT_LAST) state_nxt = ARB_RESP;
            ARB_RESP:  state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    // State register, request latches, latency counter, read capture and grant history
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ARB_IDLE;
            cnt        <= 3'd0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            lat_write  <= 1'b0;
            lat_len    <= 3'd0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata_q    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ARB_IDLE: begin
                    cnt <= 3'd0;
                    if (gnt_vld) begin
                        owner     <= gnt_idx;
                        lat_write <= gnt_idx ? p1_write : p0_write;
                        lat_len   <= gnt_idx ? p1_len   : p0_len;
                        lat_addr  <= gnt_idx ? p1_addr  : p0_addr;
                        lat_wdata <= gnt_idx ? p1_wdata : p0_wdata;
                        rdata_q   <= '0;
                    end
                end
                ARB_WAIT: begin
                    if (cnt == LAT_LAST) begin
                        rdata_q <= ram_rdata;
                        cnt     <= 3'd0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                ARB_RESP: last_grant <= owner;
                default: ;
            endcase
        end
    end

    // Strobes only in ISSUE; RAM fields hold the latched request; acks only in RESP
    always_comb begin
        ram_read  = (state == ARB_ISSUE) && !lat_write;
        ram_write = (state == ARB_ISSUE) && lat_write;
        ram_len   = lat_len;
        ram_addr  = lat_addr;
        ram_wdata = lat_wdata;
        busy      = (state != ARB_IDLE);
        p0_ack    = (state == ARB_RESP) && !owner;
        p1_ack    = (state == ARB_RESP) && owner;
        p0_rdata  = p0_ack ? rdata_q : '0;
        p1_rdata  = p1_ack ? rdata_q : '0;
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomised, self-checking bench for data_mem_arbiter against a transaction-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_data_mem_arbiter;

    localparam int L = 3;
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clock, reset;
    logic        p0_req, p0_write, p1_req, p1_write;
    logic [2:0]  p0_len, p1_len;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_ack, p1_ack;
    logic [31:0] p0_rdata, p1_rdata;
    logic        ram_read, ram_write;
    logic [2:0]  ram_len;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        busy, owner;

    int errors = 0;
    int checks = 0;

    // transaction-level reference: expected memory contents and last served port
    logic [31:0] exp_mem [logic [31:0]];
    bit          model_last;

    data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LATENCY(L)) dut (
        .clock(clock), .reset(reset),
        .p0_req(p0_req), .p0_write(p0_write), .p0_len(p0_len), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_write(p1_write), .p1_len(p1_len), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .ram_read(ram_read), .ram_write(ram_write), .ram_len(ram_len),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .busy(busy), .owner(owner)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM model: 16 words, read data valid only in the cycle L after the read strobe, junk otherwise
    logic [31:0] ram_mem [16];
    logic [7:0]  vpipe;
    logic [31:0] apipe [8];
    logic [31:0] junk;

    always @(posedge clock) begin
        junk <= $urandom;
        apipe[0] <= ram_addr;
        for (int i = 1; i < 8; i++) apipe[i] <= apipe[i-1];
        if (reset) begin
            vpipe <= 8'd0;
            for (int i = 0; i < 16; i++) ram_mem[i] <= 32'h0;
        end else begin
            vpipe <= {vpipe[6:0], ram_read};
            if (ram_write) ram_mem[ram_addr[5:2]] <= ram_wdata;
        end
    end

    assign ram_rdata = vpipe[L-1] ? ram_mem[apipe[L-1][5:2]] : junk;

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : 32'h0;
    endfunction

    function automatic logic ack_of(input int p);
        return (p == 0) ? p0_ack : p1_ack;
    endfunction

    function automatic logic [31:0] rdata_of(input int p);
        return (p == 0) ? p0_rdata : p1_rdata;
    endfunction

    task automatic drive(input int p, input logic rq, input logic wr, input logic [2:0] ln,
                         input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            p0_req = rq; p0_write = wr; p0_len = ln; p0_addr = a; p0_wdata = d;
        end else begin
            p1_req = rq; p1_write = wr; p1_len = ln; p1_addr = a; p1_wdata = d;
        end
    endtask

    task automatic set_req(input int p, input logic rq);
        if (p == 0) p0_req = rq; else p1_req = rq;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (!busy) return;
            @(negedge clock);
        end
        checks++; errors++;
        $display("FAIL wait_idle: busy=%0b after 40 cycles, required 0", busy);
    endtask

    // One access on one port, checking strobe timing, latched fields, ack latency and data
    task automatic run_single(input int port, input bit wr, input logic [2:0] len,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input bit drop_early, input string name);
        int T, ack_t, ack_n, oth_n, stb_n;
        logic r1, w1;
        logic [2:0] l1;
        logic [31:0] a1, d1, got, exp;
        T = wr ? 2 : 2 + L;
        ack_t = -1; ack_n = 0; oth_n = 0; stb_n = 0;
        r1 = 0; w1 = 0; l1 = 0; a1 = 0; d1 = 0; got = 0;
        wait_idle();
        exp = exp_rd(addr);
        drive(port, 1'b1, wr, len, addr, wdata);
        for (int t = 1; t <= T + 2; t++) begin
            @(negedge clock);
            if (ram_read || ram_write) stb_n++;
            if (t == 1) begin
                r1 = ram_read; w1 = ram_write; l1 = ram_len; a1 = ram_addr; d1 = ram_wdata;
            end
            if (ack_of(1 - port)) oth_n++;
            if (ack_of(port)) begin
                ack_n++; ack_t = t; got = rdata_of(port);
                set_req(port, 1'b0);
            end
            if (drop_early && t == 2) set_req(port, 1'b0);
        end
        checks++; if ({w1, r1} !== {wr, ~wr}) begin errors++;
            $display("FAIL %s strobe: got w/r=%0b%0b required %0b%0b", name, w1, r1, wr, ~wr); end
        checks++; if (a1 !== addr) begin errors++;
            $display("FAIL %s ram_addr: got %h required %h", name, a1, addr); end
        checks++; if (l1 !== len) begin errors++;
            $display("FAIL %s ram_len: got %0d required %0d", name, l1, len); end
        if (wr) begin
            checks++; if (d1 !== wdata) begin errors++;
                $display("FAIL %s ram_wdata: got %h required %h", name, d1, wdata); end
        end
        checks++; if (stb_n != 1) begin errors++;
            $display("FAIL %s strobe_count: got %0d required 1", name, stb_n); end
        checks++; if (ack_n != 1 || ack_t != T) begin errors++;
            $display("FAIL %s ack: got count=%0d at t=%0d required count=1 at t=%0d", name, ack_n, ack_t, T); end
        checks++; if (oth_n != 0) begin errors++;
            $display("FAIL %s other_ack: got %0d required 0", name, oth_n); end
        if (!wr) begin
            checks++; if (got !== exp) begin errors++;
                $display("FAIL %s rdata: got %h required %h", name, got, exp); end
        end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL %s busy_end: got %0b required 0", name, busy); end
        if (wr) exp_mem[addr] = wdata;
        model_last = (port != 0);
    endtask

    task automatic test_reset();
        int first;
        logic [31:0] got;
        reset = 1'b1;
        drive(0, 1'b1, 1'b0, 3'd2, 32'h20, 32'h0);
        drive(1, 1'b1, 1'b0, 3'd2, 32'h24, 32'h0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            checks++;
            if ({p0_ack, p1_ack, busy, ram_read, ram_write, owner} !== 6'b0 ||
                ram_addr !== 32'h0 || p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
                errors++;
                $display("FAIL reset_state: got ack=%0b%0b busy=%0b strb=%0b%0b owner=%0b addr=%h required all 0",
                         p0_ack, p1_ack, busy, ram_read, ram_write, owner, ram_addr);
            end
        end
        reset = 1'b0;
        exp_mem.delete();
        model_last = 1'b1;
        first = -1; got = 0;
        for (int c = 0; c < 20 && first < 0; c++) begin
            @(negedge clock);
            if (p0_ack) begin first = 0; got = p0_rdata; end
            else if (p1_ack) begin first = 1; got = p1_rdata; end
        end
        checks++; if (first != 0) begin errors++;
            $display("FAIL reset_first_grant: got port %0d required 0", first); end
        checks++; if (got !== 32'h0) begin errors++;
            $display("FAIL reset_first_rdata: got %h required 0", got); end
        p0_req = 1'b0;
        first = -1;
        for (int c = 0; c < 20 && first < 0; c++) begin
            @(negedge clock);
            if (p1_ack) first = 1;
            else if (p0_ack) first = 0;
        end
        checks++; if (first != 1) begin errors++;
            $display("FAIL reset_second_grant: got port %0d required 1", first); end
        p1_req = 1'b0;
        model_last = 1'b1;
    endtask

    task automatic test_write();
        run_single(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, "p0_write");
    endtask

    task automatic test_read();
        run_single(1, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, "p1_read");
    endtask

    task automatic test_back_to_back();
        int order [4];
        int exp_order [4];
        int n, p;
        logic [31:0] wd;
        if (FIXED) exp_order = '{0, 0, 0, 0}; else exp_order = '{0, 1, 0, 1};
        n = 0;
        wd = $urandom;
        wait_idle();
        drive(0, 1'b1, 1'b1, 3'd2, 32'h30, wd);
        drive(1, 1'b1, 1'b0, 3'd2, 32'h34, 32'h0);
        for (int c = 0; c < 80 && n < 4; c++) begin
            @(negedge clock);
            if (p0_ack || p1_ack) begin
                p = p1_ack ? 1 : 0;
                order[n] = p;
                if (p == 1) begin
                    checks++; if (p1_rdata !== exp_rd(32'h34)) begin errors++;
                        $display("FAIL b2b_rdata: got %h required %h", p1_rdata, exp_rd(32'h34)); end
                end else begin
                    exp_mem[32'h30] = wd;
                end
                model_last = (p != 0);
                n++;
                if (n == 4) begin p0_req = 1'b0; p1_req = 1'b0; end
            end
        end
        checks++; if (n != 4) begin errors++;
            $display("FAIL b2b_count: got %0d acks required 4", n); end
        for (int k = 0; k < 4; k++) begin
            if (k < n) begin
                checks++; if (order[k] != exp_order[k]) begin errors++;
                    $display("FAIL b2b_order[%0d]: got port %0d required %0d", k, order[k], exp_order[k]); end
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        int acks;
        bit in_wait;
        wait_idle();
        drive(0, 1'b1, 1'b0, 3'd2, 32'h30, 32'h0);
        @(negedge clock);
        @(negedge clock);
        in_wait = busy && !ram_read && !p0_ack;
        checks++; if (!in_wait) begin errors++;
            $display("FAIL rstmid_in_wait: got busy=%0b ack=%0b required busy=1 ack=0", busy, p0_ack); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        p0_req = 1'b0;
        exp_mem.delete();
        model_last = 1'b1;
        acks = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (p0_ack || p1_ack) acks++;
        end
        checks++; if (acks != 0 || busy !== 1'b0) begin errors++;
            $display("FAIL rstmid_no_ack: got acks=%0d busy=%0b required 0 0", acks, busy); end
        run_single(1, 1'b1, 3'd1, 32'h08, 32'hCAFE1234, 1'b0, "rstmid_write");
        run_single(0, 1'b0, 3'd1, 32'h08, 32'h0, 1'b0, "rstmid_read");
    endtask

    task automatic test_drop();
        run_single(0, 1'b0, 3'd2, 32'h08, 32'h0, 1'b1, "drop_read");
    endtask

    task automatic test_random();
        bit          pend [2];
        bit          wr [2];
        logic [31:0] ad [2];
        logic [31:0] wd [2];
        int          m, p, pred;
        bit          seen;
        for (int r = 0; r < 25; r++) begin
            m = $urandom_range(1, 3);
            wait_idle();
            for (int q = 0; q < 2; q++) begin
                pend[q] = m[q];
                wr[q]   = $urandom_range(0, 1) != 0;
                ad[q]   = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                wd[q]   = $urandom;
                drive(q, m[q], wr[q], 3'($urandom_range(0, 2)), ad[q], wd[q]);
            end
            while (pend[0] || pend[1]) begin
                seen = 1'b0;
                p = 0;
                for (int c = 0; c < 20 && !seen; c++) begin
                    @(negedge clock);
                    if (p0_ack || p1_ack) begin seen = 1'b1; p = p1_ack ? 1 : 0; end
                end
                checks++;
                if (!seen) begin
                    errors++;
                    $display("FAIL rand_timeout: round %0d no ack within 20 cycles", r);
                    p0_req = 1'b0; p1_req = 1'b0;
                    break;
                end
                if (pend[0] && pend[1]) pred = FIXED ? 0 : (model_last ? 0 : 1);
                else pred = pend[0] ? 0 : 1;
                if (p != pred || (p0_ack && p1_ack)) begin
                    errors++;
                    $display("FAIL rand_grant: round %0d got port %0d (acks %0b%0b) required %0d",
                             r, p, p0_ack, p1_ack, pred);
                end
                if (!wr[p]) begin
                    checks++;
                    if (rdata_of(p) !== exp_rd(ad[p])) begin
                        errors++;
                        $display("FAIL rand_rdata: round %0d port %0d got %h required %h",
                                 r, p, rdata_of(p), exp_rd(ad[p]));
                    end
                end else begin
                    exp_mem[ad[p]] = wd[p];
                end
                model_last = (p != 0);
                set_req(p, 1'b0);
                pend[p] = 1'b0;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        model_last = 1'b1;
        @(negedge clock);
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_drop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
